// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC engine arbiter: Q2.29 angle format,
// arbiter FSM states and the default engine pipeline depth.
package cordic_pkg;

  localparam int Q_FRAC              = 29;
  localparam int ANGLE_W             = 32;
  localparam int ENG_LATENCY_DEFAULT = 34;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DRAIN = 2'd1,
    QUIET = 2'd2
  } arb_state_e;

endpackage

// File: rtl/cordic_tag_pipe.sv
// {valid, ID} delay line that shadows the engine pipeline so each result can be
// attributed to its requester; synchronous clear empties every stage.
module cordic_tag_pipe
  import cordic_pkg::*;
#(
  parameter int DEPTH = ENG_LATENCY_DEFAULT + 1,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id
);

  logic [DEPTH-1:0]           vld_q, vld_d;
  logic [DEPTH-1:0][ID_W-1:0] id_q, id_d;

  always_comb begin
    vld_d = {vld_q[DEPTH-2:0], in_valid};
    id_d  = {id_q[DEPTH-2:0], in_id};
    if (clr) begin
      vld_d = '0;
      id_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    vld_q <= vld_d;
    id_q  <= id_d;
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one pipelined CORDIC engine among NUM_REQ requesters,
// with tagged responses and a drain/quiesce FSM. Optional CORDIC_ARB_STATS_EN adds grant counters.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ENG_LATENCY = ENG_LATENCY_DEFAULT,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*ANGLE_W-1:0]          req_angle,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [ANGLE_W-1:0]                  eng_angle,
  output logic                                eng_valid,
  input  logic [ANGLE_W-1:0]                  eng_sine,
  input  logic [ANGLE_W-1:0]                  eng_cosine,
  output logic                                rsp_valid,
  output logic [ID_W-1:0]                     rsp_id,
  output logic [ANGLE_W-1:0]                  rsp_sine,
  output logic [ANGLE_W-1:0]                  rsp_cosine,
  input  logic                                drain,
  output logic                                drained,
  output logic [$clog2(ENG_LATENCY+2)-1:0]    inflight
`ifdef CORDIC_ARB_STATS_EN
  ,
  input  logic                                stats_clr,
  output logic [NUM_REQ*16-1:0]               grant_count
`endif
);

  localparam int CNT_W = $clog2(ENG_LATENCY + 2);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic               eng_valid_q, eng_valid_d;
  logic [ANGLE_W-1:0] eng_angle_q, eng_angle_d;
  logic               drained_q, drained_d;

  logic               grant_hit;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;
  logic               tag_vld;
  logic [ID_W-1:0]    tag_id;

  // First valid requester at or after ptr, only while arbitrating.
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = '0;
    cand      = '0;
    if (state_q == ARB) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
        if (!grant_hit && req_valid[cand]) begin
          grant_hit = 1'b1;
          grant_id  = cand;
        end
      end
    end
  end

  assign req_ready = grant_hit ? (NUM_REQ'(1) << grant_id) : '0;

  always_comb begin
    eng_valid_d = grant_hit;
    eng_angle_d = grant_hit ? req_angle[int'(grant_id)*ANGLE_W +: ANGLE_W] : eng_angle_q;
    ptr_d       = ptr_q;
    if (grant_hit) begin
      ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end

    inflight_d = inflight_q;
    if (grant_hit && !tag_vld) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!grant_hit && tag_vld) begin
      inflight_d = inflight_q - 1'b1;
    end

    // Quiet is judged on the post-update count so it follows the last response directly.
    state_d = state_q;
    case (state_q)
      ARB:     if (drain) state_d = DRAIN;
      DRAIN:   if (!drain) state_d = ARB;
               else if (inflight_d == '0) state_d = QUIET;
      QUIET:   if (!drain) state_d = ARB;
      default: state_d = ARB;
    endcase
    drained_d = (state_d == QUIET);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      inflight_q  <= '0;
      eng_valid_q <= 1'b0;
      eng_angle_q <= '0;
      drained_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      eng_valid_q <= eng_valid_d;
      eng_angle_q <= eng_angle_d;
      drained_q   <= drained_d;
    end
  end

  cordic_tag_pipe #(
    .DEPTH (ENG_LATENCY + 1),
    .ID_W  (ID_W)
  ) u_tag_pipe (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (grant_hit),
    .in_id     (grant_id),
    .out_valid (tag_vld),
    .out_id    (tag_id)
  );

  assign eng_valid  = eng_valid_q;
  assign eng_angle  = eng_angle_q;
  assign drained    = drained_q;
  assign inflight   = inflight_q;
  assign rsp_valid  = tag_vld;
  assign rsp_id     = tag_id;
  assign rsp_sine   = eng_sine;
  assign rsp_cosine = eng_cosine;

`ifdef CORDIC_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

  // Saturating per-requester accept counters; clear wins over a coincident accept.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (req_ready[i] && cnt_q[i] != 16'hFFFF) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares one pipelined `cordic_engine` (Q2.29 angle in, Q2.29 sine/cosine out, one issue per cycle, no output valid, no stall) among `NUM_REQ` requesters. Round-robin grants, one issue per cycle, and a tag delay line that returns each result with its requester ID. A drain/quiesce state machine lets system control empty the pipeline before reconfiguration or clock gating. Sits between the requester fabric and the engine instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ENG_LATENCY`, 34: cycles from the engine sampling `input_valid` to valid `sine`/`cosine`.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester ID.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_angle`  in  NUM_REQ*32  Q2.29 angles; slice i belongs to requester i.
- `req_ready`  out  NUM_REQ  one-hot grant.
- `eng_angle`  out  32  to engine `angle_in` (registered).
- `eng_valid`  out  1  to engine `input_valid` (registered).
- `eng_sine`, `eng_cosine`  in  32 each  engine results.
- `rsp_valid`  out  1  result pulse.
- `rsp_id`  out  ID_W  requester that owns the result.
- `rsp_sine`, `rsp_cosine`  out  32 each  pass-through of the engine results, qualified by `rsp_valid`.
- `drain`  in  1  level request to quiesce.
- `drained`  out  1  high in QUIET.
- `inflight`  out  `$clog2(ENG_LATENCY+2)`  outstanding issues.

## Operation
- Handshake: accept on `req_valid[i] & req_ready[i]`. A requester holds `req_angle` stable until accepted.
- `req_ready` is combinational from `req_valid`, the RR pointer and the state. At most one bit is high, and only in state ARB.
- Round-robin:
  - Search starts at `ptr`.
  - After a grant to requester g, `ptr` becomes `(g+1) mod NUM_REQ`.
  - `ptr` is unchanged when there is no grant.
- Accept cycle: the granted angle is registered into `eng_angle`, `eng_valid` is set to 1, and the ID is pushed into the tag line. `eng_valid`=0 whenever there is no accept; `eng_angle` holds its last value.
- Tag line: `ENG_LATENCY`+1 stages of {valid, ID}. The output stage drives `rsp_valid`/`rsp_id`.
- `inflight`: +1 on accept, −1 on `rsp_valid`, unchanged when both occur in the same cycle. Maximum value is `ENG_LATENCY`+1; it never wraps.
- FSM:
  - ARB: grants are enabled. Goes to DRAIN when `drain`=1.
  - DRAIN: no grants. Returns to ARB if `drain`=0. Goes to QUIET when `inflight`=0.
  - QUIET: `drained`=1 and no grants. Returns to ARB when `drain`=0.
- The `drain` check takes effect in the cycle after it is sampled: an accept in the same cycle `drain` rises still completes.
- Reset, including mid-operation:
  - state=ARB, `ptr`=0, tag line cleared, `inflight`=0.
  - `eng_valid`=0, `eng_angle`=0.
  - `rsp_valid`=0, `rsp_id`=0, `drained`=0.
  - Results already in the engine are discarded, never reported.

## Timing
- Accept in cycle T gives `eng_valid`=1 in cycle T+1 and `rsp_valid`=1 in cycle T+1+`ENG_LATENCY` (T+35 at default).
- Throughput is one accept per cycle. Back-to-back accepts produce back-to-back responses in issue order.
- `rsp_valid` is a single-cycle pulse. There is no response backpressure; consumers capture in the cycle it is high.
- QUIET is entered, at the earliest, in the cycle after the last `rsp_valid`.

## Configuration
- `CORDIC_ARB_STATS_EN` defined:
  - Adds input `stats_clr` (1 bit) and output `grant_count` (NUM_REQ*16 bits).
  - Each requester has a saturating 16-bit accept counter that holds at 0xFFFF.
  - Counters are cleared by `rst` or `stats_clr`. If `stats_clr` and an accept occur in the same cycle, the counter goes to 0.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package `cordic_pkg`:
  - Q2.29 format constants (`Q_FRAC`=29, `ANGLE_W`=32).
  - FSM state enum {ARB, DRAIN, QUIET}.
  - Default `ENG_LATENCY`.
- Sub-module `cordic_tag_pipe`: a parameterized {valid, ID} shift register of depth `ENG_LATENCY`+1 with synchronous clear.

## Test plan
- Single request: requester 2 presents 0x1921FB54 (π/4) and is accepted at T. Expect `rsp_valid` at T+35 with `rsp_id`=2, sine and cosine ≈0x16A09E66 (±8 LSB), and `inflight` back to 0.
- All four requesters held valid for 8 cycles. Expect grants in order 0,1,2,3,0,1,2,3, and the same `rsp_id` order 35 cycles later with no gaps.
- `drain` raised with 5 requests in flight. Expect `req_ready`=0 from the next cycle, `drained`=1 the cycle after the 5th `rsp_valid`, and grants resuming one cycle after `drain` falls.
- `drain` raised then dropped while in DRAIN. Expect a return to ARB with no lost or duplicated responses.
- `rst` pulsed 10 cycles after 3 accepts. Expect all outputs at reset values, no `rsp_valid` for the pre-reset requests, `ptr`=0, and requester 0 granted first afterwards.
- With `CORDIC_ARB_STATS_EN`: 3 accepts from requester 1 give `grant_count[1]`=3. `stats_clr` coincident with an accept gives 0.
